fifo_rr_drain_arbiter: RTL and testbench



---
 rtl/fifo_rr_drain_arbiter_if.sv | 26 ++
 rtl/fifo_rr_drain_arbiter.sv | 154 +++++++++++++++
 tb/tb_fifo_rr_drain_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rr_drain_arbiter_if.sv
// Fifo read-port bundle plus the tagged valid/ready output stream of the drain arbiter.
// The arbiter takes the master side; the fifos and the sample consumer take the slave side.
interface fifo_rr_drain_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 24,
  parameter int CH_W       = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]            fifo_empty;
  logic [NUM_CH*DATA_WIDTH-1:0] fifo_dout;
  logic [NUM_CH-1:0]            fifo_rd_en;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [CH_W-1:0]              out_ch;
  logic                         out_last;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_rd_en, out_valid, out_data, out_ch, out_last
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_ch, out_last
  );
endinterface

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain of NUM_CH registered-output fifos into one tagged valid/ready stream,
// taking up to BURST_LEN consecutive words from a channel before rotating.
module fifo_rr_drain_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 24,
  parameter int BURST_LEN  = 2,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic              busy,
  fifo_rr_drain_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_HOLD
  } state_t;

  localparam logic [7:0]    LAST_CNT = 8'(BURST_LEN - 1);
  localparam logic [CH_W:0] NUM_CH_X = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0] MAX_CH = CH_W'(NUM_CH - 1);

  state_t                state_q, state_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [7:0]            burst_cnt_q, burst_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;
  logic                  out_last_q, out_last_d;

  logic [NUM_CH-1:0]     elig;
  logic [2*NUM_CH-1:0]   elig_rot;
  logic                  pick_found;
  logic [CH_W-1:0]       pick;
  logic [CH_W:0]         pick_sum;
  logic [CH_W-1:0]       next_ptr;
  logic [NUM_CH-1:0]     rd_en;
  logic [DATA_WIDTH-1:0] dout_sel;

  assign elig = ch_enable & ~bus.fifo_empty;

  // Rotate the eligibility vector so bit 0 is rr_ptr, then take the first set bit and map back mod NUM_CH.
  always_comb begin
    elig_rot   = {elig, elig} >> rr_ptr_q;
    pick_found = 1'b0;
    pick_sum   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!pick_found && elig_rot[k]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, rr_ptr_q} + (CH_W + 1)'(k);
      end
    end
    if (pick_sum >= NUM_CH_X) begin
      pick_sum = pick_sum - NUM_CH_X;
    end
    pick = pick_sum[CH_W-1:0];
  end

  always_comb begin
    next_ptr = (grant_q == MAX_CH) ? '0 : grant_q + CH_W'(1);
    dout_sel = bus.fifo_dout[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    rd_en = '0;
    if (state_q == S_READ) begin
      rd_en[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d     = pick;
          burst_cnt_d = '0;
          state_d     = S_READ;
        end
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // The continue/rotate decision is frozen here, using the post-read empty flag.
        out_data_d  = dout_sel;
        out_ch_d    = grant_q;
        out_valid_d = 1'b1;
        out_last_d  = (burst_cnt_q == LAST_CNT) | bus.fifo_empty[grant_q] | ~ch_enable[grant_q];
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            rr_ptr_d = next_ptr;
            state_d  = S_IDLE;
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
            state_d     = S_READ;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_ch     = out_ch_q;
  assign bus.out_last   = out_last_q;
  assign busy           = (state_q != S_IDLE);

  a_rd_en_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(rd_en));

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Drives fifo_rr_drain_arbiter from four behavioural registered-output fifos and checks
// every accepted output word against a scoreboard queue.
module tb_fifo_rr_drain_arbiter;
  localparam int NUM_CH     = 4;
  localparam int DATA_WIDTH = 24;
  localparam int BURST_LEN  = 2;
  localparam int CH_W       = 2;
  localparam int DEPTH      = 16;

  typedef struct packed {
    logic [1:0]  ch;
    logic [23:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [3:0]  en;
    logic [1:0]  ch;
    logic [23:0] data;
    logic [1:0]  exp_ch;
    logic        exp_last;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  ch_enable;
  logic        busy;
  logic        push_en;
  logic        fifo_clear;
  logic [1:0]  push_ch;
  logic [23:0] push_data;

  logic [23:0] mem [NUM_CH][DEPTH];
  logic [23:0] dout [NUM_CH];
  int          wr_ptr [NUM_CH];
  int          rd_ptr [NUM_CH];
  int          count [NUM_CH];

  beat_t       sb [$];
  int          acc_times [$];
  int          cycle;
  int          checks;
  int          passed;
  logic [3:0]  prev_rd_en;
  vec_t        vecs [6];

  fifo_rr_drain_arbiter_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DATA_WIDTH), .CH_W(CH_W)) bus ();

  fifo_rr_drain_arbiter #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DATA_WIDTH), .BURST_LEN(BURST_LEN), .CH_W(CH_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ch_enable(ch_enable),
    .busy(busy),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Registered-output fifo models: dout updates on the edge that sees rd_en.
  always @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (fifo_clear) begin
        wr_ptr[i] <= 0;
        rd_ptr[i] <= 0;
        count[i]  <= 0;
      end else begin
        if (bus.fifo_rd_en[i] && count[i] > 0) begin
          dout[i]   <= mem[i][rd_ptr[i]];
          rd_ptr[i] <= (rd_ptr[i] + 1) % DEPTH;
        end
        if (push_en && int'(push_ch) == i) begin
          mem[i][wr_ptr[i]] <= push_data;
          wr_ptr[i]         <= (wr_ptr[i] + 1) % DEPTH;
        end
        count[i] <= count[i]
                    - ((bus.fifo_rd_en[i] && count[i] > 0) ? 1 : 0)
                    + ((push_en && int'(push_ch) == i) ? 1 : 0);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo_out
    assign bus.fifo_empty[g] = (count[g] == 0);
    assign bus.fifo_dout[g*DATA_WIDTH +: DATA_WIDTH] = dout[g];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Samples what the DUT will see at the coming edge, then advances one cycle to the next negedge.
  task automatic tick();
    beat_t got;
    beat_t exp;
    if (!reset) begin
      if (bus.fifo_rd_en != 4'd0) begin
        check_output("rd_en_onehot", 32'($countones(bus.fifo_rd_en)), 32'd1);
        check_output("rd_en_width", 32'(prev_rd_en), 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        got = '{bus.out_ch, bus.out_data, bus.out_last};
        if (sb.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no output (cycle %0d)", got, cycle);
        end else begin
          exp = sb.pop_front();
          check_output("beat{ch,data,last}", 32'(got), 32'(exp));
        end
        acc_times.push_back(cycle);
      end
    end
    prev_rd_en = bus.fifo_rd_en;
    @(posedge clock);
    @(negedge clock);
    cycle++;
  endtask

  task automatic apply_stimulus(input logic [1:0] ch, input logic [23:0] data);
    push_ch   = ch;
    push_data = data;
    push_en   = 1'b1;
    tick();
    push_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    fifo_clear = 1'b1;
    ch_enable  = 4'd0;
    bus.out_ready = 1'b0;
    push_en    = 1'b0;
    tick();
    tick();
    fifo_clear = 1'b0;
    reset      = 1'b0;
    sb.delete();
    acc_times.delete();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_output("drain_remaining", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      tick();
      n++;
    end
    check_output("wait_out_valid", 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    checks     = 0;
    passed     = 0;
    cycle      = 0;
    prev_rd_en = 4'd0;
    reset      = 1'b1;
    fifo_clear = 1'b1;
    ch_enable  = 4'd0;
    push_en    = 1'b0;
    push_ch    = 2'd0;
    push_data  = 24'd0;
    bus.out_ready = 1'b0;
    @(negedge clock);

    vecs[0] = '{4'hF,    2'd0, 24'hABCDEF, 2'd0, 1'b1};
    vecs[1] = '{4'hF,    2'd3, 24'hFFFFFF, 2'd3, 1'b1};
    vecs[2] = '{4'b0100, 2'd2, 24'h000000, 2'd2, 1'b1};
    vecs[3] = '{4'b0010, 2'd1, 24'h5A5A5A, 2'd1, 1'b1};
    vecs[4] = '{4'hF,    2'd2, 24'h800001, 2'd2, 1'b1};
    vecs[5] = '{4'b1001, 2'd3, 24'h123456, 2'd3, 1'b1};

    // Reset values, checked while reset is still held.
    do_reset();
    reset = 1'b1;
    #1;
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_out_data", 32'(bus.out_data), 32'd0);
    check_output("rst_out_ch", 32'(bus.out_ch), 32'd0);
    check_output("rst_out_last", 32'(bus.out_last), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    do_reset();

    // Idle with all fifos empty and every channel enabled.
    ch_enable = 4'hF;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      check_output("idle_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      check_output("idle_out_valid", 32'(bus.out_valid), 32'd0);
      check_output("idle_busy", 32'(busy), 32'd0);
      tick();
    end

    // Table of single-word transfers; each fifo goes empty on its read so out_last is 1.
    for (int v = 0; v < 6; v++) begin
      ch_enable = vecs[v].en;
      sb.push_back('{vecs[v].exp_ch, vecs[v].data, vecs[v].exp_last});
      apply_stimulus(vecs[v].ch, vecs[v].data);
      wait_drain(40);
      tick();
      check_output("vec_busy_after", 32'(busy), 32'd0);
    end

    // Single channel, three words: burst of two, rotate, then the third.
    do_reset();
    bus.out_ready = 1'b1;
    apply_stimulus(2'd1, 24'h000011);
    apply_stimulus(2'd1, 24'h000022);
    apply_stimulus(2'd1, 24'h000033);
    sb.push_back('{2'd1, 24'h000011, 1'b0});
    sb.push_back('{2'd1, 24'h000022, 1'b1});
    sb.push_back('{2'd1, 24'h000033, 1'b1});
    ch_enable = 4'hF;
    wait_drain(60);
    check_output("single_accept_count", 32'(acc_times.size()), 32'd3);
    if (acc_times.size() == 3) begin
      check_output("single_gap_burst", 32'(acc_times[1] - acc_times[0]), 32'd3);
      check_output("single_gap_rotate", 32'(acc_times[2] - acc_times[1]), 32'd4);
    end

    // Round-robin between ch0 and ch3 with four words each.
    do_reset();
    for (int w = 0; w < 4; w++) begin
      apply_stimulus(2'd0, 24'h000100 + 24'(w));
      apply_stimulus(2'd3, 24'h000300 + 24'(w));
    end
    for (int r = 0; r < 2; r++) begin
      sb.push_back('{2'd0, 24'h000100 + 24'(2*r), 1'b0});
      sb.push_back('{2'd0, 24'h000101 + 24'(2*r), 1'b1});
      sb.push_back('{2'd3, 24'h000300 + 24'(2*r), 1'b0});
      sb.push_back('{2'd3, 24'h000301 + 24'(2*r), 1'b1});
    end
    bus.out_ready = 1'b1;
    ch_enable = 4'hF;
    wait_drain(120);

    // Backpressure: held word stays stable, no further reads.
    do_reset();
    apply_stimulus(2'd2, 24'h000200);
    apply_stimulus(2'd2, 24'h000201);
    apply_stimulus(2'd2, 24'h000202);
    sb.push_back('{2'd2, 24'h000200, 1'b0});
    sb.push_back('{2'd2, 24'h000201, 1'b1});
    sb.push_back('{2'd2, 24'h000202, 1'b1});
    ch_enable = 4'hF;
    wait_valid(20);
    for (int c = 0; c < 20; c++) begin
      check_output("bp_out_data", 32'(bus.out_data), 32'h000200);
      check_output("bp_out_ch", 32'(bus.out_ch), 32'd2);
      check_output("bp_out_last", 32'(bus.out_last), 32'd0);
      check_output("bp_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      check_output("bp_occupancy", 32'(count[2]), 32'd2);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_drain(60);

    // Enable masking, then dropping ch0 enable while its second read is committed.
    do_reset();
    apply_stimulus(2'd2, 24'h000C20);
    apply_stimulus(2'd2, 24'h000C21);
    apply_stimulus(2'd0, 24'h000C00);
    apply_stimulus(2'd0, 24'h000C01);
    apply_stimulus(2'd0, 24'h000C02);
    sb.push_back('{2'd0, 24'h000C00, 1'b0});
    sb.push_back('{2'd0, 24'h000C01, 1'b1});
    ch_enable = 4'b1011;
    wait_valid(20);
    check_output("mask_first_ch", 32'(bus.out_ch), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    ch_enable = 4'b1010;
    check_output("mask_committed_rd_en", 32'(bus.fifo_rd_en), 32'b0001);
    wait_drain(30);
    for (int c = 0; c < 10; c++) tick();
    check_output("mask_busy_after", 32'(busy), 32'd0);
    check_output("mask_ch0_left", 32'(count[0]), 32'd1);
    check_output("mask_ch2_untouched", 32'(count[2]), 32'd2);

    // Async reset while a word is held, then the first grant restarts at ch0.
    do_reset();
    bus.out_ready = 1'b1;
    ch_enable = 4'hF;
    sb.push_back('{2'd1, 24'h000D11, 1'b1});
    apply_stimulus(2'd1, 24'h000D11);
    wait_drain(40);
    ch_enable = 4'd0;
    bus.out_ready = 1'b0;
    apply_stimulus(2'd2, 24'h000D20);
    apply_stimulus(2'd2, 24'h000D21);
    apply_stimulus(2'd0, 24'h000D00);
    ch_enable = 4'b0101;
    wait_valid(20);
    check_output("pre_reset_grant_ch", 32'(bus.out_ch), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check_output("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("async_rst_busy", 32'(busy), 32'd0);
    check_output("async_rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    sb.push_back('{2'd0, 24'h000D00, 1'b1});
    sb.push_back('{2'd2, 24'h000D21, 1'b1});
    bus.out_ready = 1'b1;
    wait_drain(60);
    check_output("post_reset_ch2_empty", 32'(count[2]), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
